// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin N-port arbiter onto one single-ported sync-read memory.
// Define MEM_ARB_PERF_EN to add per-port saturating grant/stall counters readable via dbg_sel.
module mem_arbiter #(
    parameter int N_PORTS = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int SEL_W   = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_PORTS-1:0]          req_r_en,
    input  logic [N_PORTS*ADDR_W-1:0]   req_r_addr,
    input  logic [N_PORTS-1:0]          req_w_en,
    input  logic [N_PORTS*ADDR_W-1:0]   req_w_addr,
    input  logic [N_PORTS*DATA_W-1:0]   req_w_data,
    output logic [N_PORTS-1:0]          req_ready,
    output logic [N_PORTS-1:0]          resp_r_valid,
    output logic [DATA_W-1:0]           resp_r_data,
    output logic                        mem_r_en,
    output logic [ADDR_W-1:0]           mem_r_addr,
    output logic                        mem_w_en,
    output logic [ADDR_W-1:0]           mem_w_addr,
    output logic [DATA_W-1:0]           mem_w_data,
    input  logic [DATA_W-1:0]           mem_r_data,
    input  logic [SEL_W:0]              dbg_sel,
    output logic [31:0]                 dbg_data
);
    logic [N_PORTS-1:0] req;
    logic               gnt_v;
    logic [SEL_W-1:0]   gnt_idx;
    logic [SEL_W-1:0]   idx;
    logic [SEL_W-1:0]   last_q, last_d;
    logic [SEL_W-1:0]   pend_port_q;
    logic               pend_v_q;

    assign req = req_r_en | req_w_en;

    // Search starts just after the last winner and wraps once around all ports.
    always_comb begin
        gnt_v   = 1'b0;
        gnt_idx = '0;
        idx     = '0;
        for (int i = 1; i <= N_PORTS; i++) begin
            idx = SEL_W'((int'(last_q) + i) % N_PORTS);
            if (!gnt_v && req[idx]) begin
                gnt_v   = 1'b1;
                gnt_idx = idx;
            end
        end
    end

    assign last_d       = gnt_v ? gnt_idx : last_q;
    assign req_ready    = gnt_v ? N_PORTS'(1) << gnt_idx : '0;
    assign mem_r_en     = gnt_v & req_r_en[gnt_idx];
    assign mem_w_en     = gnt_v & req_w_en[gnt_idx];
    assign mem_r_addr   = gnt_v ? req_r_addr[gnt_idx*ADDR_W +: ADDR_W] : '0;
    assign mem_w_addr   = gnt_v ? req_w_addr[gnt_idx*ADDR_W +: ADDR_W] : '0;
    assign mem_w_data   = gnt_v ? req_w_data[gnt_idx*DATA_W +: DATA_W] : '0;
    assign resp_r_valid = pend_v_q ? N_PORTS'(1) << pend_port_q : '0;
    assign resp_r_data  = mem_r_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q      <= SEL_W'(N_PORTS - 1);
            pend_port_q <= '0;
            pend_v_q    <= 1'b0;
        end else begin
            last_q      <= last_d;
            pend_port_q <= gnt_idx;
            pend_v_q    <= mem_r_en;
        end
    end

`ifdef MEM_ARB_PERF_EN
    logic [31:0]      grant_cnt_q [N_PORTS];
    logic [31:0]      stall_cnt_q [N_PORTS];
    logic [SEL_W-1:0] dbg_port;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N_PORTS; k++) begin
                grant_cnt_q[k] <= '0;
                stall_cnt_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N_PORTS; k++) begin
                if (req_ready[k] && grant_cnt_q[k] != '1)
                    grant_cnt_q[k] <= grant_cnt_q[k] + 32'd1;
                if (req[k] && !req_ready[k] && stall_cnt_q[k] != '1)
                    stall_cnt_q[k] <= stall_cnt_q[k] + 32'd1;
            end
        end
    end

    assign dbg_port = dbg_sel[SEL_W:1];
    assign dbg_data = (int'(dbg_port) >= N_PORTS) ? '0 :
                      dbg_sel[0] ? stall_cnt_q[dbg_port] : grant_cnt_q[dbg_port];
`else
    logic unused_dbg;
    assign unused_dbg = ^dbg_sel;
    assign dbg_data   = '0;
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter with N_PORTS=4 against a small sync-read memory.
module tb_mem_arbiter;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_r_en, req_w_en, req_ready, resp_r_valid;
    logic [N*AW-1:0] req_r_addr, req_w_addr;
    logic [N*DW-1:0] req_w_data;
    logic [DW-1:0]   resp_r_data, mem_w_data, mem_r_data;
    logic            mem_r_en, mem_w_en;
    logic [AW-1:0]   mem_r_addr, mem_w_addr;
    logic [SW:0]     dbg_sel;
    logic [31:0]     dbg_data;
    logic [31:0]     mem [256];
    int              checks = 0;
    int              errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.N_PORTS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .req_r_en(req_r_en), .req_r_addr(req_r_addr),
        .req_w_en(req_w_en), .req_w_addr(req_w_addr), .req_w_data(req_w_data),
        .req_ready(req_ready), .resp_r_valid(resp_r_valid), .resp_r_data(resp_r_data),
        .mem_r_en(mem_r_en), .mem_r_addr(mem_r_addr),
        .mem_w_en(mem_w_en), .mem_w_addr(mem_w_addr), .mem_w_data(mem_w_data),
        .mem_r_data(mem_r_data), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    // Synchronous-read memory; old data on same-address read/write. Preloaded while in reset.
    always @(posedge clk) begin
        if (rst) mem[8'h10] <= 32'hCAFE0001;
        if (mem_w_en) mem[mem_w_addr[7:0]] <= mem_w_data;
        if (mem_r_en) mem_r_data <= mem[mem_r_addr[7:0]];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        req_r_en = '0; req_w_en = '0;
        req_r_addr = '0; req_w_addr = '0; req_w_data = '0;
    endtask

    task automatic rd(input int p, input logic [31:0] a);
        req_r_en[p] = 1'b1;
        req_r_addr[p*AW +: AW] = a;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        dbg_sel = '0;
        clr();
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_ready", req_ready, 4'b0000);
        check("rst_mem_r_en", mem_r_en, 1'b0);
        check("rst_mem_w_en", mem_w_en, 1'b0);
        check("rst_resp_v", resp_r_valid, 4'b0000);
        check("rst_mem_r_addr", mem_r_addr, 32'h0);

        rd(0, 32'h10);
        #1;
        check("single_ready", req_ready, 4'b0001);
        check("single_mem_r_en", mem_r_en, 1'b1);
        check("single_addr", mem_r_addr, 32'h10);
        tick();
        clr();
        #1;
        check("single_resp_v", resp_r_valid, 4'b0001);
        check("single_resp_d", resp_r_data, 32'hCAFE0001);
        check("single_idle_ready", req_ready, 4'b0000);

        do_reset();
        for (int p = 0; p < N; p++) rd(p, 32'h40 + p * 4);
        for (int i = 0; i < 8; i++) begin
            #1;
            check($sformatf("rr_ready%0d", i), req_ready, 4'b0001 << (i % 4));
            check($sformatf("rr_raddr%0d", i), mem_r_addr, 32'h40 + (i % 4) * 4);
            check($sformatf("rr_resp%0d", i), resp_r_valid,
                  (i == 0) ? 4'b0000 : 4'b0001 << ((i - 1) % 4));
            tick();
        end
        clr();
        #1;
        check("rr_resp_last", resp_r_valid, 4'b1000);

        do_reset();
        rd(0, 32'h20);
        req_w_en[1] = 1'b1;
        req_w_addr[1*AW +: AW] = 32'h20;
        req_w_data[1*DW +: DW] = 32'h12345678;
        #1;
        check("rw_first_ready", req_ready, 4'b0001);
        check("rw_first_w_en", mem_w_en, 1'b0);
        tick();
        req_r_en[0] = 1'b0;
        #1;
        check("rw_second_ready", req_ready, 4'b0010);
        check("rw_w_en", mem_w_en, 1'b1);
        check("rw_w_addr", mem_w_addr, 32'h20);
        check("rw_w_data", mem_w_data, 32'h12345678);
        check("rw_r_en_off", mem_r_en, 1'b0);
        check("rw_resp_port0", resp_r_valid, 4'b0001);
        tick();
        clr();
        rd(0, 32'h20);
        #1;
        check("rw_reread_ready", req_ready, 4'b0001);
        tick();
        clr();
        #1;
        check("rw_reread_v", resp_r_valid, 4'b0001);
        check("rw_reread_d", resp_r_data, 32'h12345678);

        do_reset();
        rd(2, 32'h10);
        #1;
        check("rst_mid_ready", req_ready, 4'b0100);
        tick();
        clr();
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_resp", resp_r_valid, 4'b0000);
        tick();
        rst = 1'b0;
        check("rst_mid_after", resp_r_valid, 4'b0000);
        rd(0, 32'h10);
        rd(2, 32'h10);
        #1;
        check("rst_mid_contest", req_ready, 4'b0001);
        tick();
        clr();
        #1;
        check("rst_mid_no_replay", resp_r_valid, 4'b0001);

        do_reset();
        rd(0, 32'h10);
        rd(1, 32'h14);
        for (int i = 0; i < 10; i++) tick();
        clr();
        for (int s = 0; s < 8; s++) begin
            dbg_sel = 3'(s);
            #1;
`ifdef MEM_ARB_PERF_EN
            check($sformatf("perf_sel%0d", s), dbg_data, (s < 4) ? 32'd5 : 32'd0);
`else
            check($sformatf("perf_off_sel%0d", s), dbg_data, 32'd0);
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
